// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared constants and types for the direct-mapped instruction cache:
//   LINES / IDX_W / ADDR_W defaults, derived tag width, boolean constants and
//   the controller state encoding (IDLE / MISS).
// -----------------------------------------------------------------------------
package icache_pkg;

  localparam int LINES  = 256;
  localparam int IDX_W  = 8;
  localparam int ADDR_W = 18;
  localparam int TAG_W  = ADDR_W - IDX_W - 2;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MISS = 1'b1
  } state_e;

endpackage

// File: rtl/icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
// Storage for the direct-mapped cache: per-line valid bits (cleared by reset),
// tag RAM and data RAM. Reads are asynchronous by index, writes are synchronous.
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset (valid bits)
//   rd_idx_i                   lookup index
//   rd_valid_o/rd_tag_o/rd_data_o  contents of the indexed line
//   we_i, wr_idx_i, wr_tag_i, wr_data_i  line fill port
// -----------------------------------------------------------------------------
module icache_array
  import icache_pkg::*;
#(
  parameter int LINES_P = LINES,
  parameter int IDX_W_P = IDX_W,
  parameter int TAG_W_P = TAG_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [IDX_W_P-1:0] rd_idx_i,
  output logic               rd_valid_o,
  output logic [TAG_W_P-1:0] rd_tag_o,
  output logic [31:0]        rd_data_o,
  input  logic               we_i,
  input  logic [IDX_W_P-1:0] wr_idx_i,
  input  logic [TAG_W_P-1:0] wr_tag_i,
  input  logic [31:0]        wr_data_i
);

  logic [LINES_P-1:0] valid_q;
  logic [TAG_W_P-1:0] tag_q  [LINES_P];
  logic [31:0]        data_q [LINES_P];

  // Valid bits: cleared by reset, set by a fill.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= TRUE;
    end else begin
      valid_q <= valid_q;
    end
  end

  // Tag and data RAMs: no reset, only written on a fill.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
// Direct-mapped, one-word-per-line instruction cache between fetch and the
// memory controller. Hits return in one cycle; misses request the aligned word
// on ic_valid/ic_ain, fill the line on ic_enable and return the word.
// Ports:
//   clk, rst_n (sync, active low), rdy (0 = pause), clear (drop pending request)
//   fetch_valid, fetch_pc        fetch request, held until inst_valid or clear
//   inst_valid, inst             one-cycle result pulse and instruction word
//   ic_valid, ic_ain             memory request (held for the whole miss)
//   ic_enable, ic_dout           memory response pulse and data
// -----------------------------------------------------------------------------
module icache
  import icache_pkg::*;
#(
  parameter int LINES_P  = LINES,
  parameter int IDX_W_P  = IDX_W,
  parameter int ADDR_W_P = ADDR_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        clear,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic        ic_valid,
  output logic [31:0] ic_ain,
  input  logic        ic_enable,
  input  logic [31:0] ic_dout
);

  localparam int TAG_W_P = ADDR_W_P - IDX_W_P - 2;

  state_e      state_q;
  logic        inst_valid_q;
  logic [31:0] inst_q;
  logic        ic_valid_q;
  logic [31:0] ic_ain_q;

  logic [IDX_W_P-1:0] idx_s;
  logic [TAG_W_P-1:0] tag_s;
  logic               rd_valid_s;
  logic [TAG_W_P-1:0] rd_tag_s;
  logic [31:0]        rd_data_s;
  logic               hit_s;
  logic               lookup_s;
  logic               fill_s;
  logic               unused_s;

  assign idx_s = fetch_pc[IDX_W_P+1:2];
  assign tag_s = fetch_pc[ADDR_W_P-1:IDX_W_P+2];
  assign hit_s = rd_valid_s && (rd_tag_s == tag_s);

  // Skip the lookup in the cycle inst_valid is high: the requester is only
  // now advancing its pc, so the held pc would be served twice.
  assign lookup_s = fetch_valid && !inst_valid_q && !clear;

  // A fill happens on the response even if clear arrives with it; the fill
  // address comes from the latched request so address and data always match.
  assign fill_s = rdy && (state_q == S_MISS) && ic_enable;

  // Bits outside the index/tag fields and the unused request-address bits.
  assign unused_s = ^{fetch_pc[31:ADDR_W_P], fetch_pc[1:0],
                      ic_ain_q[31:ADDR_W_P], ic_ain_q[1:0]};

  icache_array #(
    .LINES_P (LINES_P),
    .IDX_W_P (IDX_W_P),
    .TAG_W_P (TAG_W_P)
  ) u_array (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rd_idx_i   (idx_s),
    .rd_valid_o (rd_valid_s),
    .rd_tag_o   (rd_tag_s),
    .rd_data_o  (rd_data_s),
    .we_i       (fill_s),
    .wr_idx_i   (ic_ain_q[IDX_W_P+1:2]),
    .wr_tag_i   (ic_ain_q[ADDR_W_P-1:IDX_W_P+2]),
    .wr_data_i  (ic_dout)
  );

  // Controller FSM with registered request and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      inst_valid_q <= FALSE;
      inst_q       <= 32'h0000_0000;
      ic_valid_q   <= FALSE;
      ic_ain_q     <= 32'h0000_0000;
    end else if (!rdy) begin
      inst_valid_q <= FALSE;
    end else begin
      inst_valid_q <= FALSE;
      case (state_q)
        S_IDLE: begin
          if (lookup_s) begin
            if (hit_s) begin
              inst_q       <= rd_data_s;
              inst_valid_q <= TRUE;
            end else begin
              ic_valid_q <= TRUE;
              ic_ain_q   <= {fetch_pc[31:2], 2'b00};
              state_q    <= S_MISS;
            end
          end
        end
        S_MISS: begin
          if (ic_enable) begin
            // Aborted requests still fill but do not deliver the word.
            if (!clear) begin
              inst_q       <= ic_dout;
              inst_valid_q <= TRUE;
            end
            ic_valid_q <= FALSE;
            state_q    <= S_IDLE;
          end else if (clear) begin
            ic_valid_q <= FALSE;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          ic_valid_q <= FALSE;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign ic_valid   = ic_valid_q;
  assign ic_ain     = ic_ain_q;

endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache
// Self-checking bench for icache: a table of fetch vectors plus hand-written
// sequences for clear, pause and reset during a miss. Returned instructions are
// checked against a scoreboard queue filled when stimulus is driven.
// -----------------------------------------------------------------------------
module tb_icache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic        ic_valid;
  logic [31:0] ic_ain;
  logic        ic_enable = 1'b0;
  logic [31:0] ic_dout = 32'h0;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] dout;
    logic        hit;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs[12];

  icache dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rdy         (rdy),
    .clear       (clear),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .ic_valid    (ic_valid),
    .ic_ain      (ic_ain),
    .ic_enable   (ic_enable),
    .ic_dout     (ic_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && inst_valid) begin
      if (sb_q.size() == 0) chk("unexpected_inst_valid", {31'd0, inst_valid}, 32'd0);
      else chk("inst", inst, sb_q.pop_front());
    end
  end

  task automatic wait_req(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (ic_valid) ok = 1'b1;
    end
    chk({name, "_req_seen"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic fetch(input string name, input logic [31:0] pc, input logic [31:0] dout,
                       input logic exp_hit, input logic [31:0] exp_inst);
    int cyc;
    bit done;
    bit saw;
    cyc = 0; done = 1'b0; saw = 1'b0;
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    if (exp_hit) sb_q.push_back(exp_inst);
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (inst_valid) begin
        done = 1'b1;
      end else if (ic_valid && !saw) begin
        saw = 1'b1;
        chk({name, "_ain"}, ic_ain, {pc[31:2], 2'b00});
        repeat (2) @(negedge clk);
        chk({name, "_req_hold"}, {31'd0, ic_valid}, 32'd1);
        ic_enable = 1'b1;
        ic_dout   = dout;
        if (!exp_hit) sb_q.push_back(exp_inst);
        @(negedge clk);
        ic_enable = 1'b0;
        cyc += 3;
        if (inst_valid) done = 1'b1;
      end
    end
    fetch_valid = 1'b0;
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_missed"}, {31'd0, saw}, {31'd0, ~exp_hit});
    if (exp_hit) chk({name, "_hit_latency"}, cyc, 32'd1);
    chk({name, "_req_idle"}, {31'd0, ic_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{pc: 32'h0000_0000, dout: 32'h0000_0013, hit: 1'b0, exp_inst: 32'h0000_0013};
    vecs[1]  = '{pc: 32'h0000_0000, dout: 32'h0000_0000, hit: 1'b1, exp_inst: 32'h0000_0013};
    vecs[2]  = '{pc: 32'h0000_0003, dout: 32'h0000_0000, hit: 1'b1, exp_inst: 32'h0000_0013};
    vecs[3]  = '{pc: 32'h0000_0004, dout: 32'hAAAA_0001, hit: 1'b0, exp_inst: 32'hAAAA_0001};
    vecs[4]  = '{pc: 32'h0000_0404, dout: 32'hBBBB_0002, hit: 1'b0, exp_inst: 32'hBBBB_0002};
    vecs[5]  = '{pc: 32'h0000_0004, dout: 32'hAAAA_0003, hit: 1'b0, exp_inst: 32'hAAAA_0003};
    vecs[6]  = '{pc: 32'h0000_0004, dout: 32'h0000_0000, hit: 1'b1, exp_inst: 32'hAAAA_0003};
    vecs[7]  = '{pc: 32'h0003_FFFC, dout: 32'hCCCC_0004, hit: 1'b0, exp_inst: 32'hCCCC_0004};
    vecs[8]  = '{pc: 32'h0003_FFFC, dout: 32'h0000_0000, hit: 1'b1, exp_inst: 32'hCCCC_0004};
    vecs[9]  = '{pc: 32'h4003_FFFC, dout: 32'h0000_0000, hit: 1'b1, exp_inst: 32'hCCCC_0004};
    vecs[10] = '{pc: 32'h0000_0800, dout: 32'h1111_0005, hit: 1'b0, exp_inst: 32'h1111_0005};
    vecs[11] = '{pc: 32'h0000_0000, dout: 32'h6666_0006, hit: 1'b0, exp_inst: 32'h6666_0006};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ic_valid", {31'd0, ic_valid}, 32'd0);
    chk("rst_ic_ain", ic_ain, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].dout, vecs[i].hit, vecs[i].exp_inst);
    end

    // Clear two cycles into a miss, then a stale response in IDLE.
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_pc    = 32'h0000_0100;
    wait_req("clr");
    @(negedge clk);
    clear       = 1'b1;
    fetch_valid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_ic_valid_fall", {31'd0, ic_valid}, 32'd0);
    ic_enable = 1'b1;
    ic_dout   = 32'hDEAD_0000;
    @(negedge clk);
    ic_enable = 1'b0;
    chk("stale_no_result", {31'd0, inst_valid}, 32'd0);
    fetch("clr_refetch", 32'h0000_0100, 32'h2222_0006, 1'b0, 32'h2222_0006);

    // Clear coinciding with the response: line filled, no result.
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_pc    = 32'h0000_0200;
    wait_req("clren");
    @(negedge clk);
    ic_enable   = 1'b1;
    ic_dout     = 32'h3333_0007;
    clear       = 1'b1;
    fetch_valid = 1'b0;
    @(negedge clk);
    ic_enable = 1'b0;
    clear     = 1'b0;
    chk("clren_ic_valid", {31'd0, ic_valid}, 32'd0);
    chk("clren_no_result", {31'd0, inst_valid}, 32'd0);
    fetch("clren_hit", 32'h0000_0200, 32'h0, 1'b1, 32'h3333_0007);

    // Pause for three cycles mid-miss, including a response that must be ignored.
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_pc    = 32'h0000_0300;
    wait_req("pause");
    rdy       = 1'b0;
    ic_enable = 1'b1;
    ic_dout   = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ic_enable = 1'b0;
      chk("pause_ic_valid", {31'd0, ic_valid}, 32'd1);
      chk("pause_ic_ain", ic_ain, 32'h0000_0300);
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("pause_resume_ic_valid", {31'd0, ic_valid}, 32'd1);
    ic_enable = 1'b1;
    ic_dout   = 32'h4444_0008;
    sb_q.push_back(32'h4444_0008);
    @(negedge clk);
    ic_enable   = 1'b0;
    fetch_valid = 1'b0;
    chk("pause_result", {31'd0, inst_valid}, 32'd1);
    fetch("pause_hit", 32'h0000_0300, 32'h0, 1'b1, 32'h4444_0008);

    // Reset mid-miss clears requests and valid bits.
    @(negedge clk);
    fetch_valid = 1'b1;
    fetch_pc    = 32'h0000_0500;
    wait_req("rstmid");
    rst_n       = 1'b0;
    fetch_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid_ic_valid", {31'd0, ic_valid}, 32'd0);
    chk("rstmid_ic_ain", ic_ain, 32'd0);
    chk("rstmid_inst_valid", {31'd0, inst_valid}, 32'd0);
    rst_n = 1'b1;
    fetch("rstmid_refetch", 32'h0000_0300, 32'h5555_0009, 1'b0, 32'h5555_0009);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
